cc_uart_core: RTL and testbench



---
 rtl/cc_uart_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_cc_uart_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_uart_core.sv
// cc_uart_core: full-duplex UART with generic bit timing, a first-word-fall-through RX FIFO and explicit errors.
// Optional parity bit on TX and RX is compiled in with `define CC_UART_PARITY_EN.
module cc_uart_core #(
    parameter int CLK_FREQ_HZ   = 30_000_000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 rx_err,
    output logic [1:0]           rx_err_type,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int AW  = $clog2(RX_FIFO_DEPTH);
    localparam int SW  = DATA_BITS + 2;
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_e;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_e;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic [1:0]           sync_q, sync_d;
    logic                 rx_line_s;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bits_q, rx_bits_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_err_q, rx_par_err_d;
    logic                 rx_done_q, rx_done_d, rx_err_q, rx_err_d;
    logic [1:0]           rx_err_type_q, rx_err_type_d;
    logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [RX_FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 push_s, pop_s, full_s, empty_s;
    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bits_q, tx_bits_d;
    logic [SW-1:0]        tx_shift_q, tx_shift_d;
    logic                 tx_top_s;
    logic                 tx_out_q, tx_out_d, tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;

    assign rx_line_s = sync_q[1];
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s     = rx_ready & ~empty_s;
`ifdef CC_UART_PARITY_EN
    assign tx_top_s  = parity_of(tx_data);
`else
    assign tx_top_s  = 1'b1;
`endif

    assign rx_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid    = ~empty_s;
    assign rx_done     = rx_done_q;
    assign rx_err      = rx_err_q;
    assign rx_err_type = rx_err_type_q;
    assign tx_out      = tx_out_q;
    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;

    // RX synchroniser, receive FSM and the stop-bit verdict (push / done / error)
    always_comb begin
        sync_d        = {sync_q[0], rx_in};
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bits_d     = rx_bits_q;
        rx_shift_d    = rx_shift_q;
        rx_par_err_d  = rx_par_err_q;
        rx_err_type_d = rx_err_type_q;
        rx_done_d     = 1'b0;
        rx_err_d      = 1'b0;
        push_s        = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (!rx_line_s) begin
                    rx_state_d   = R_START;
                    rx_cnt_d     = CNT_HALF;
                    rx_par_err_d = 1'b0;
                end else begin
                    rx_cnt_d = rx_cnt_q;
                end
            end
            R_START: begin
                if (rx_cnt_q != CNT_ZERO) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else if (!rx_line_s) begin
                    rx_state_d = R_DATA;
                    rx_cnt_d   = CNT_BIT;
                    rx_bits_d  = BW'(0);
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rx_cnt_q != CNT_ZERO) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else begin
                    rx_cnt_d   = CNT_BIT;
                    rx_shift_d = {rx_line_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bits_q == LAST_BIT) begin
`ifdef CC_UART_PARITY_EN
                        rx_state_d = R_PARITY;
`else
                        rx_state_d = R_STOP;
`endif
                    end else begin
                        rx_bits_d = rx_bits_q + BW'(1);
                    end
                end
            end
            R_PARITY: begin
                if (rx_cnt_q != CNT_ZERO) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else begin
                    rx_cnt_d     = CNT_BIT;
                    rx_par_err_d = (rx_line_s != parity_of(rx_shift_q));
                    rx_state_d   = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt_q != CNT_ZERO) begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end else if (!rx_line_s) begin
                    rx_err_d      = 1'b1;
                    rx_err_type_d = 2'b01;
                    rx_state_d    = R_WAIT;
                end else if (rx_par_err_q) begin
                    rx_err_d      = 1'b1;
                    rx_err_type_d = 2'b10;
                    rx_state_d    = R_IDLE;
                end else if (full_s && !pop_s) begin
                    rx_err_d      = 1'b1;
                    rx_err_type_d = 2'b11;
                    rx_state_d    = R_IDLE;
                end else begin
                    push_s     = 1'b1;
                    rx_done_d  = 1'b1;
                    rx_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rx_line_s) begin
                    rx_state_d = R_IDLE;
                end else begin
                    rx_state_d = R_WAIT;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // FIFO storage and pointer updates; pointers carry one wrap bit
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_s);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop_s);
    end

    // TX FSM: a {top, data, start} frame shifts out LSB first, ones fill from the top
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                tx_out_d  = 1'b1;
                tx_busy_d = 1'b0;
                if (tx_start) begin
                    tx_state_d = T_START;
                    tx_cnt_d   = CNT_BIT;
                    tx_shift_d = {tx_top_s, tx_data, 1'b0};
                    tx_out_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_START, T_DATA, T_PARITY, T_STOP: begin
                if (tx_cnt_q != CNT_ZERO) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else begin
                    tx_cnt_d   = CNT_BIT;
                    tx_shift_d = {1'b1, tx_shift_q[SW-1:1]};
                    tx_out_d   = tx_shift_q[1];
                    case (tx_state_q)
                        T_START: begin
                            tx_state_d = T_DATA;
                            tx_bits_d  = BW'(0);
                        end
                        T_DATA: begin
                            if (tx_bits_q == LAST_BIT) begin
`ifdef CC_UART_PARITY_EN
                                tx_state_d = T_PARITY;
`else
                                tx_state_d = T_STOP;
`endif
                            end else begin
                                tx_bits_d = tx_bits_q + BW'(1);
                            end
                        end
                        T_PARITY: tx_state_d = T_STOP;
                        default: begin
                            tx_state_d = T_IDLE;
                            tx_out_d   = 1'b1;
                            tx_busy_d  = 1'b0;
                            tx_done_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // State registers; reset aborts both directions and empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 2'b11;
            rx_state_q    <= R_IDLE;
            rx_cnt_q      <= CNT_ZERO;
            rx_bits_q     <= BW'(0);
            rx_shift_q    <= {DATA_BITS{1'b0}};
            rx_par_err_q  <= 1'b0;
            rx_done_q     <= 1'b0;
            rx_err_q      <= 1'b0;
            rx_err_type_q <= 2'b00;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_q      <= (AW + 1)'(0);
            rd_ptr_q      <= (AW + 1)'(0);
            tx_state_q    <= T_IDLE;
            tx_cnt_q      <= CNT_ZERO;
            tx_bits_q     <= BW'(0);
            tx_shift_q    <= {SW{1'b1}};
            tx_out_q      <= 1'b1;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bits_q     <= rx_bits_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_err_q  <= rx_par_err_d;
            rx_done_q     <= rx_done_d;
            rx_err_q      <= rx_err_d;
            rx_err_type_q <= rx_err_type_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bits_q     <= tx_bits_d;
            tx_shift_q    <= tx_shift_d;
            tx_out_q      <= tx_out_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
        end
    end
endmodule

// File: tb/tb_cc_uart_core.sv
// Bench for cc_uart_core: random TX/RX traffic compared against a frame-level model with a queue as the FIFO.
`timescale 1ns/1ps
module tb_cc_uart_core;
    localparam int CLK_HZ = 921600;
    localparam int BAUD   = 115200;
    localparam int DB     = 8;
    localparam int DEPTH  = 4;
    localparam int PODD   = 0;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef CC_UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB    = 2 + DB + P;
    localparam int FRAME = NB * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic          rx_ready = 1'b0;
    logic          tx_start = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_done, rx_err, tx_out, tx_busy, tx_done;
    logic [1:0]    rx_err_type;

    always #5 clk = ~clk;

    cc_uart_core #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB),
        .RX_FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_done(rx_done), .rx_err(rx_err), .rx_err_type(rx_err_type),
        .tx_data(tx_data), .tx_start(tx_start), .tx_out(tx_out),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    int            n_checks = 0;
    int            n_pass = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            both_cnt = 0;
    int            exp_done = 0;
    int            exp_err = 0;
    logic [1:0]    exp_type = 2'b00;
    logic [DB-1:0] model_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic par_of(input logic [DB-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    // pulse monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done) done_cnt++;
            if (rx_err) err_cnt++;
            if (rx_done && rx_err) both_cnt++;
        end
    end

    // Expects the accept edge to be the next posedge; optionally chains the next word in the done cycle.
    task automatic tx_frame(input logic [DB-1:0] d, input bit chain, input logic [DB-1:0] nxt);
        logic exp_bits[NB];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) exp_bits[1 + i] = d[i];
        if (P == 1) exp_bits[1 + DB] = par_of(d);
        exp_bits[NB - 1] = 1'b1;
        for (int i = 1; i <= FRAME + 1; i++) begin
            @(negedge clk);
            if (i <= FRAME) begin
                check("tx_out", tx_out, exp_bits[(i - 1) / DIV]);
                check("tx_busy", tx_busy, 1);
                check("tx_done_early", tx_done, 0);
            end else begin
                check("tx_done", tx_done, 1);
                check("tx_busy_end", tx_busy, 0);
                check("tx_idle_line", tx_out, 1);
            end
            tx_start = (i == 20) || (i == FRAME + 1 && chain);
            tx_data  = (i == 20) ? ~d : (chain ? nxt : d);
        end
    endtask

    task automatic send_rx(input logic [DB-1:0] d, input logic stop_v, input logic par_flip,
                           input int tail_low);
        logic b[NB];
        b[0] = 1'b0;
        for (int i = 0; i < DB; i++) b[1 + i] = d[i];
        if (P == 1) b[1 + DB] = par_of(d) ^ par_flip;
        b[NB - 1] = stop_v;
        for (int i = 0; i < NB; i++) begin
            rx_in = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_in = 1'b0;
        repeat (tail_low) @(negedge clk);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic model_rx(input logic [DB-1:0] d);
        if (model_q.size() < DEPTH) begin
            model_q.push_back(d);
            exp_done++;
        end else begin
            exp_err++;
            exp_type = 2'b11;
        end
    endtask

    task automatic check_counts();
        check("rx_done_cnt", done_cnt, exp_done);
        check("rx_err_cnt", err_cnt, exp_err);
        check("rx_err_type", rx_err_type, exp_type);
    endtask

    task automatic pop_one();
        check("rx_valid", rx_valid, 1);
        check("rx_data", rx_data, model_q.pop_front());
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pop_all();
        int n;
        n = model_q.size();
        for (int i = 0; i < n; i++) pop_one();
        check("rx_valid_empty", rx_valid, 0);
    endtask

    logic [DB-1:0] d0, d1, d2, w;
    logic [DB-1:0] words[5];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_rx_err", rx_err, 0);
        check("rst_rx_err_type", rx_err_type, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // TX: A5 then two random words back to back, with a request during busy each time
        d0 = 8'hA5;
        d1 = DB'($urandom);
        d2 = DB'($urandom);
        tx_start = 1'b1;
        tx_data  = d0;
        tx_frame(d0, 1'b1, d1);
        tx_frame(d1, 1'b1, d2);
        tx_frame(d2, 1'b0, d0);
        @(negedge clk);
        check("tx_done_single", tx_done, 0);
        check("tx_no_queue", tx_busy, 0);
`ifdef CC_UART_PARITY_EN
        tx_start = 1'b1;
        tx_data  = 8'h07;
        tx_frame(8'h07, 1'b0, 8'h00);
        @(negedge clk);
`endif

        // RX fill to overflow, then drain
        words = '{8'h3C, 8'h7E, 8'h01, 8'hFF, 8'h55};
        for (int k = 0; k < 5; k++) begin
            send_rx(words[k], 1'b1, 1'b0, 0);
            model_rx(words[k]);
            check_counts();
        end
        pop_all();

        // random traffic with occasional pops
        for (int k = 0; k < 8; k++) begin
            w = DB'($urandom);
            send_rx(w, 1'b1, 1'b0, 0);
            model_rx(w);
            check_counts();
            if ($urandom_range(0, 1) == 1 && model_q.size() > 0) pop_one();
        end
        pop_all();

        // framing error with the line held low afterwards
        send_rx(8'h12, 1'b0, 1'b0, 40);
        exp_err++;
        exp_type = 2'b01;
        check_counts();
        repeat (100) @(negedge clk);
        check_counts();
        check("frm_no_push", rx_valid, 0);

        // short glitch
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (100) @(negedge clk);
        check_counts();
        check("glitch_no_push", rx_valid, 0);

`ifdef CC_UART_PARITY_EN
        send_rx(8'h07, 1'b1, 1'b1, 0);
        exp_err++;
        exp_type = 2'b10;
        check_counts();
        check("par_no_push", rx_valid, 0);
`endif

        // reset mid-frame with two FIFO entries
        for (int k = 0; k < 2; k++) begin
            w = DB'($urandom);
            send_rx(w, 1'b1, 1'b0, 0);
            model_rx(w);
        end
        check_counts();
        tx_start = 1'b1;
        tx_data  = DB'($urandom);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (29) @(negedge clk);
        check("pre_rst_busy", tx_busy, 1);
        check("pre_rst_valid", rx_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_tx_out", tx_out, 1);
        check("async_tx_busy", tx_busy, 0);
        check("async_rx_valid", rx_valid, 0);
        check("async_rx_data", rx_data, 0);
        model_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", tx_out, 1);
        check("done_err_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
